plugin_collector: RTL

PLUGIN_COLLECTOR -- requirements
Module: plugin_collector

---
 rtl/plugin_collector.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/plugin_collector.sv
// -----------------------------------------------------------------------------
// plugin_collector
//
// Broadcasts a start pulse to a set of plugins, waits for their results, and
// reduces the returned warp vectors and error values to one saturated result.
// The result is offered on a valid/ready handshake.
//
// Sequence: IDLE -> START -> COLLECT -> ACCUM -> DONE -> IDLE
//   START   : one-cycle plugin_start pulse; the accumulators and flags are cleared
//   COLLECT : waits until every plugin is valid or TIMEOUT cycles have elapsed
//   ACCUM   : adds plugin i in ACCUM cycle i, skipping plugins that never answered
//   DONE    : presents the saturated result until res_valid && res_ready
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   req                 collection request, accepted only in IDLE
//   busy                high whenever the block is not IDLE
//   plugin_start        start pulse, high for the single START cycle
//   plugin_valid        per-plugin valid, bit i = plugin i
//   plugin_warp_x/y/z   packed signed warp components, plugin i at [i*WARP_WIDTH +: WARP_WIDTH]
//   plugin_error        packed unsigned errors, plugin i at [i*ERROR_WIDTH +: ERROR_WIDTH]
//   err_threshold       error limit, sampled on entry to DONE
//   res_valid/res_ready result handshake
//   res_warp_x/y/z      saturated signed warp sums
//   res_error_sum       saturated error sum
//   res_overflow        any warp axis saturated
//   res_err_exceed      res_error_sum > err_threshold
//   res_timeout         at least one plugin was missing when COLLECT ended
//   res_missing         plugins that were not valid when COLLECT ended
// -----------------------------------------------------------------------------
module plugin_collector #(
  parameter int NUM_PLUGINS = 5,
  parameter int WARP_WIDTH  = 16,
  parameter int ERROR_WIDTH = 32,
  parameter int TIMEOUT     = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              req,
  output logic                              busy,
  output logic                              plugin_start,
  input  logic [NUM_PLUGINS-1:0]            plugin_valid,
  input  logic [NUM_PLUGINS*WARP_WIDTH-1:0] plugin_warp_x,
  input  logic [NUM_PLUGINS*WARP_WIDTH-1:0] plugin_warp_y,
  input  logic [NUM_PLUGINS*WARP_WIDTH-1:0] plugin_warp_z,
  input  logic [NUM_PLUGINS*ERROR_WIDTH-1:0] plugin_error,
  input  logic [ERROR_WIDTH-1:0]            err_threshold,
  output logic                              res_valid,
  input  logic                              res_ready,
  output logic [WARP_WIDTH-1:0]             res_warp_x,
  output logic [WARP_WIDTH-1:0]             res_warp_y,
  output logic [WARP_WIDTH-1:0]             res_warp_z,
  output logic [ERROR_WIDTH-1:0]            res_error_sum,
  output logic                              res_overflow,
  output logic                              res_err_exceed,
  output logic                              res_timeout,
  output logic [NUM_PLUGINS-1:0]            res_missing
);

  // Four guard bits hold the sum of up to 16 full-scale plugins without wrap.
  localparam int AW    = WARP_WIDTH + 4;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int IDX_W = (NUM_PLUGINS > 1) ? $clog2(NUM_PLUGINS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_PLUGINS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_COLLECT,
    S_ACCUM,
    S_DONE
  } state_t;

  state_t state, state_next;

  logic [CNT_W-1:0]       cnt;
  logic [IDX_W-1:0]       idx;
  logic signed [AW-1:0]   acc_x, acc_y, acc_z;
  logic signed [AW-1:0]   acc_x_next, acc_y_next, acc_z_next;
  logic [ERROR_WIDTH-1:0] err_acc, err_next;
  logic [ERROR_WIDTH:0]   err_wide;

  logic signed [WARP_WIDTH-1:0] sel_x, sel_y, sel_z;
  logic [ERROR_WIDTH-1:0]       sel_err;
  logic                         sel_en;

  logic collect_exit;
  logic accum_last;
  logic [WARP_WIDTH:0] sat_x, sat_y, sat_z;

  // Clamp a wide accumulator into the WARP_WIDTH signed range.
  // Returns {saturated, value}. The value fits when every bit from the
  // WARP_WIDTH-1 position upward is a copy of the sign bit.
  function automatic logic [WARP_WIDTH:0] saturate(input logic signed [AW-1:0] a);
    logic [AW-WARP_WIDTH:0] top;
    top = a[AW-1:WARP_WIDTH-1];
    if (top == '0 || top == '1)
      return {1'b0, a[WARP_WIDTH-1:0]};
    else if (a[AW-1])
      return {1'b1, 1'b1, {(WARP_WIDTH-1){1'b0}}};
    else
      return {1'b1, 1'b0, {(WARP_WIDTH-1){1'b1}}};
  endfunction

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  assign collect_exit = (&plugin_valid) || (cnt == CNT_LAST);
  assign accum_last   = (idx == IDX_LAST);

  // ---------------------------------------------------------------------------
  // Next state and state-decoded outputs
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_next   = state;
    busy         = (state != S_IDLE);
    plugin_start = (state == S_START);
    res_valid    = (state == S_DONE);
    case (state)
      S_IDLE:    if (req) state_next = S_START;
      S_START:   state_next = S_COLLECT;
      S_COLLECT: if (collect_exit) state_next = S_ACCUM;
      S_ACCUM:   if (accum_last) state_next = S_DONE;
      S_DONE:    if (res_ready) state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Plugin selection for the current ACCUM slot; missing plugins add zero.
  // ---------------------------------------------------------------------------
  always_comb begin
    sel_x   = '0;
    sel_y   = '0;
    sel_z   = '0;
    sel_err = '0;
    sel_en  = 1'b0;
    for (int i = 0; i < NUM_PLUGINS; i++) begin
      if (idx == IDX_W'(i)) begin
        sel_en  = ~res_missing[i];
        sel_x   = plugin_warp_x[i*WARP_WIDTH +: WARP_WIDTH];
        sel_y   = plugin_warp_y[i*WARP_WIDTH +: WARP_WIDTH];
        sel_z   = plugin_warp_z[i*WARP_WIDTH +: WARP_WIDTH];
        sel_err = plugin_error[i*ERROR_WIDTH +: ERROR_WIDTH];
      end
    end
    if (!sel_en) begin
      sel_x   = '0;
      sel_y   = '0;
      sel_z   = '0;
      sel_err = '0;
    end
  end

  always_comb begin
    acc_x_next = acc_x + {{(AW-WARP_WIDTH){sel_x[WARP_WIDTH-1]}}, sel_x};
    acc_y_next = acc_y + {{(AW-WARP_WIDTH){sel_y[WARP_WIDTH-1]}}, sel_y};
    acc_z_next = acc_z + {{(AW-WARP_WIDTH){sel_z[WARP_WIDTH-1]}}, sel_z};
    // One extra bit catches the carry; a carry pins the sum at all-ones.
    err_wide   = {1'b0, err_acc} + {1'b0, sel_err};
    err_next   = err_wide[ERROR_WIDTH] ? '1 : err_wide[ERROR_WIDTH-1:0];
    sat_x      = saturate(acc_x_next);
    sat_y      = saturate(acc_y_next);
    sat_z      = saturate(acc_z_next);
  end

  // ---------------------------------------------------------------------------
  // Datapath: counters, accumulators and result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt            <= '0;
      idx            <= '0;
      acc_x          <= '0;
      acc_y          <= '0;
      acc_z          <= '0;
      err_acc        <= '0;
      res_warp_x     <= '0;
      res_warp_y     <= '0;
      res_warp_z     <= '0;
      res_error_sum  <= '0;
      res_overflow   <= 1'b0;
      res_err_exceed <= 1'b0;
      res_timeout    <= 1'b0;
      res_missing    <= '0;
    end else begin
      case (state)
        S_START: begin
          cnt            <= '0;
          idx            <= '0;
          acc_x          <= '0;
          acc_y          <= '0;
          acc_z          <= '0;
          err_acc        <= '0;
          res_warp_x     <= '0;
          res_warp_y     <= '0;
          res_warp_z     <= '0;
          res_error_sum  <= '0;
          res_overflow   <= 1'b0;
          res_err_exceed <= 1'b0;
          res_timeout    <= 1'b0;
          res_missing    <= '0;
        end
        S_COLLECT: begin
          cnt <= cnt + 1'b1;
          // The missing mask is frozen here; late arrivals never count.
          if (collect_exit) begin
            res_missing <= ~plugin_valid;
            res_timeout <= ~(&plugin_valid);
          end
        end
        S_ACCUM: begin
          acc_x   <= acc_x_next;
          acc_y   <= acc_y_next;
          acc_z   <= acc_z_next;
          err_acc <= err_next;
          idx     <= idx + 1'b1;
          // Last slot: publish the clamped sums, including this slot's addend.
          if (accum_last) begin
            res_warp_x     <= sat_x[WARP_WIDTH-1:0];
            res_warp_y     <= sat_y[WARP_WIDTH-1:0];
            res_warp_z     <= sat_z[WARP_WIDTH-1:0];
            res_overflow   <= sat_x[WARP_WIDTH] | sat_y[WARP_WIDTH] | sat_z[WARP_WIDTH];
            res_error_sum  <= err_next;
            res_err_exceed <= (err_next > err_threshold);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
